// File: rtl/icap_load_seq.sv
// Counted SPI-flash to ICAP loader: FAST_READ command, byte-wise streaming into the
// 8-bit ICAP port, sync-word supervision and a one-cycle done pulse per transfer.
module icap_load_seq #(
    parameter int unsigned SYNC_LIMIT = 64,
    parameter bit          BITSWAP    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] addr,
    input  logic [23:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sync_ok,
    output logic        spi_cs_b,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        icap_ce_b,
    output logic        icap_we_b,
    output logic [7:0]  icap_d
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_DATA   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
    localparam logic [31:0] SYNC_WORD     = 32'hAA99_5566;
    localparam logic [23:0] LIMIT_W       = 24'(SYNC_LIMIT);

    // ICAP expects bit 0 of each configuration byte on D[7].
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [39:0] cmd_sr_r, cmd_sr_s;
    logic [5:0]  bit_cnt_r, bit_cnt_s;
    logic        phase_r, phase_s;
    logic [6:0]  rx_sr_r, rx_sr_s;
    logic [7:0]  rx_byte_s;
    logic [23:0] byte_cnt_r, byte_cnt_s;
    logic [23:0] len_r, len_s;
    logic [23:0] win_r, win_s;
    logic [7:0]  icap_d_r, icap_d_s;
    logic        icap_ce_b_r, icap_we_b_r;
    logic        strobe_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        sync_ok_r, sync_ok_s;
    logic        cs_b_r, cs_b_s;
    logic        sck_r, sck_s;
    logic        mosi_r, mosi_s;
    logic        fin_s;
    logic [39:0] cmd_word_s;

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        cmd_sr_s   = cmd_sr_r;
        bit_cnt_s  = bit_cnt_r;
        phase_s    = phase_r;
        rx_sr_s    = rx_sr_r;
        rx_byte_s  = {rx_sr_r, spi_miso};
        byte_cnt_s = byte_cnt_r;
        len_s      = len_r;
        win_s      = win_r;
        icap_d_s   = icap_d_r;
        strobe_s   = 1'b0;
        busy_s     = busy_r;
        done_s     = 1'b0;
        err_s      = err_r;
        sync_ok_s  = sync_ok_r;
        cs_b_s     = cs_b_r;
        sck_s      = sck_r;
        mosi_s     = mosi_r;
        fin_s      = 1'b0;
        cmd_word_s = {CMD_FAST_READ, addr, 8'h00};

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    len_s      = len;
                    err_s      = 1'b0;
                    sync_ok_s  = 1'b0;
                    byte_cnt_s = 24'd0;
                    win_s      = 24'd0;
                    if (len == 24'd0) begin
                        fin_s = 1'b1;
                    end else begin
                        state_s   = ST_CMD;
                        busy_s    = 1'b1;
                        cs_b_s    = 1'b0;
                        sck_s     = 1'b0;
                        mosi_s    = cmd_word_s[39];
                        cmd_sr_s  = {cmd_word_s[38:0], 1'b0};
                        bit_cnt_s = 6'd0;
                        phase_s   = 1'b0;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_CMD: begin
                if (abort) begin
                    fin_s = 1'b1;
                    err_s = 1'b1;
                end else if (!phase_r) begin
                    sck_s   = 1'b1;
                    phase_s = 1'b1;
                end else begin
                    sck_s   = 1'b0;
                    phase_s = 1'b0;
                    if (bit_cnt_r == 6'd39) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 6'd0;
                        mosi_s    = 1'b0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                        mosi_s    = cmd_sr_r[39];
                        cmd_sr_s  = {cmd_sr_r[38:0], 1'b0};
                    end
                end
            end
            ST_DATA: begin
                // Completion checks run in the strobe cycle, so the last byte is always delivered.
                if (abort) begin
                    fin_s = 1'b1;
                    err_s = 1'b1;
                end else if (!icap_ce_b_r && ((byte_cnt_r == len_r) ||
                             (!sync_ok_r && (byte_cnt_r == LIMIT_W)))) begin
                    fin_s = 1'b1;
                    err_s = !sync_ok_r;
                end else if (!phase_r) begin
                    sck_s   = 1'b1;
                    phase_s = 1'b1;
                end else begin
                    sck_s   = 1'b0;
                    phase_s = 1'b0;
                    rx_sr_s = rx_byte_s[6:0];
                    if (bit_cnt_r[2:0] == 3'd7) begin
                        bit_cnt_s  = 6'd0;
                        strobe_s   = 1'b1;
                        icap_d_s   = (BITSWAP != 1'b0) ? bit_rev8(rx_byte_s) : rx_byte_s;
                        byte_cnt_s = byte_cnt_r + 24'd1;
                        win_s      = {win_r[15:0], rx_byte_s};
                        sync_ok_s  = sync_ok_r | ({win_r, rx_byte_s} == SYNC_WORD);
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cs_b_s  = 1'b1;
                sck_s   = 1'b0;
                mosi_s  = 1'b0;
            end
        endcase

        if (fin_s) begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            cs_b_s  = 1'b1;
            sck_s   = 1'b0;
            mosi_s  = 1'b0;
            phase_s = 1'b0;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and output registers; every port is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_sr_r    <= 40'd0;
            bit_cnt_r   <= 6'd0;
            phase_r     <= 1'b0;
            rx_sr_r     <= 7'd0;
            byte_cnt_r  <= 24'd0;
            len_r       <= 24'd0;
            win_r       <= 24'd0;
            icap_d_r    <= 8'd0;
            icap_ce_b_r <= 1'b1;
            icap_we_b_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            sync_ok_r   <= 1'b0;
            cs_b_r      <= 1'b1;
            sck_r       <= 1'b0;
            mosi_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_sr_r    <= cmd_sr_s;
            bit_cnt_r   <= bit_cnt_s;
            phase_r     <= phase_s;
            rx_sr_r     <= rx_sr_s;
            byte_cnt_r  <= byte_cnt_s;
            len_r       <= len_s;
            win_r       <= win_s;
            icap_d_r    <= icap_d_s;
            icap_ce_b_r <= ~strobe_s;
            icap_we_b_r <= ~strobe_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            sync_ok_r   <= sync_ok_s;
            cs_b_r      <= cs_b_s;
            sck_r       <= sck_s;
            mosi_r      <= mosi_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign sync_ok   = sync_ok_r;
    assign spi_cs_b  = cs_b_r;
    assign spi_sck   = sck_r;
    assign spi_mosi  = mosi_r;
    assign icap_ce_b = icap_ce_b_r;
    assign icap_we_b = icap_we_b_r;
    assign icap_d    = icap_d_r;

endmodule
